sobel_window_gen: RTL

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_line_buffer.sv | 31 +++
 rtl/sobel_window_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator and the Sobel core.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // Window tap order. The centre tap is not carried, so P4 has no slot.
  typedef enum logic [2:0] {
    TAP_P0, TAP_P1, TAP_P2,
    TAP_P3,         TAP_P5,
    TAP_P6, TAP_P7, TAP_P8
  } tap_e;

  localparam int NUM_TAPS = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: synchronous write, registered read-before-write.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int DEPTH = 640,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [0:DEPTH-1];

  // Storage array; contents are meaningless until a line has been written.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register returns the value held before this access's write and
  // holds between accesses so the window stays frozen during input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for a raster pixel stream feeding the Sobel core.
// The two line buffers alternate roles by row parity: the buffer being
// written on row r still holds row r-2 at the addressed column (read-before-
// write), and the other one holds row r-1. The read registers of the line
// buffers form the right column of the window directly, which keeps the
// pixel-to-window latency at one clock.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  output logic             win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, cur_col;
  logic [RW-1:0] row_q, cur_row;

  pix_t rd_a, rd_b;
  pix_t top_new, mid_new;
  pix_t top0, top1, mid0, mid1, bot0, bot1, pix_q;
  logic par_q;
  pix_t taps [NUM_TAPS];

  // Position of the pixel on the bus; sof restarts the frame at (0,0).
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
  end

  // Raster position counters, advanced only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_valid) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_valid),
    .we    (~cur_row[0]),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (rd_a)
  );

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_valid),
    .we    (cur_row[0]),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (rd_b)
  );

  // par_q is the parity of the row last accepted; that row's buffer held r-2.
  always_comb begin
    top_new = par_q ? rd_b : rd_a;
    mid_new = par_q ? rd_a : rd_b;
  end

  // Window shift: left two columns move left, right column comes from the line buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top0  <= '0;
      top1  <= '0;
      mid0  <= '0;
      mid1  <= '0;
      bot0  <= '0;
      bot1  <= '0;
      pix_q <= '0;
      par_q <= 1'b0;
    end else if (pix_valid) begin
      top0  <= top1;
      top1  <= top_new;
      mid0  <= mid1;
      mid1  <= mid_new;
      bot0  <= bot1;
      bot1  <= pix_q;
      pix_q <= pix_in;
      par_q <= cur_row[0];
    end
  end

  // Window strobes: interior positions only, last one at the frame's final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      win_last  <= pix_valid && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end
  end

  // Map window registers onto the shared tap order.
  always_comb begin
    taps[TAP_P0] = top0;
    taps[TAP_P1] = top1;
    taps[TAP_P2] = top_new;
    taps[TAP_P3] = mid0;
    taps[TAP_P5] = mid_new;
    taps[TAP_P6] = bot0;
    taps[TAP_P7] = bot1;
    taps[TAP_P8] = pix_q;
  end

  assign p0 = taps[TAP_P0];
  assign p1 = taps[TAP_P1];
  assign p2 = taps[TAP_P2];
  assign p3 = taps[TAP_P3];
  assign p5 = taps[TAP_P5];
  assign p6 = taps[TAP_P6];
  assign p7 = taps[TAP_P7];
  assign p8 = taps[TAP_P8];

endmodule
